// File: rtl/mbs_fsk_rx.sv
// Receive end of the mbsFSK link: classifies each symbol as mark or space by half-period length,
// then seeds a local x^5+x^3+1 LFSR and checks later bits against it, reporting lock and an error count.
module mbs_fsk_rx #(
   parameter int SYM_CYCLES = 128,
   parameter int THRESH     = 6,
   parameter int LOCK_RUN   = 5,
   parameter int LOSS_RUN   = 3
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       en,
   input  logic       fsk_in,
   input  logic       err_clr,
   output logic       rx_bit,
   output logic       rx_valid,
   output logic       lock,
   output logic [4:0] lfsr_state,
   output logic [7:0] err_count
);
   localparam int SCW = $clog2(SYM_CYCLES);
   localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;

   state_t         r_state, w_state_nxt;
   logic [1:0]     r_sync;
   logic           r_prev, r_edge;
   logic [6:0]     r_hp;
   logic [7:0]     r_mark, r_space;
   logic [SCW-1:0] r_sym_cnt;
   logic [2:0]     r_seed_cnt, w_seed_cnt_nxt;
   logic [7:0]     r_match_run, w_match_run_nxt;
   logic [7:0]     r_miss_run, w_miss_run_nxt;
   logic [4:0]     r_lfsr, w_lfsr_nxt;
   logic           r_lock, w_lock_nxt;
   logic [7:0]     r_err, w_err_nxt;
   logic           r_rx_bit, r_rx_valid;

   logic           w_short, w_mark_inc, w_space_inc, w_decide, w_bit, w_pred;
   logic [7:0]     w_mark_sum, w_space_sum;

   // Vote sums include an edge landing in the decision cycle itself
   assign w_short     = r_hp < 7'(THRESH);
   assign w_mark_inc  = r_edge & w_short;
   assign w_space_inc = r_edge & ~w_short;
   assign w_mark_sum  = (r_mark == 8'hFF) ? r_mark : r_mark + {7'd0, w_mark_inc};
   assign w_space_sum = (r_space == 8'hFF) ? r_space : r_space + {7'd0, w_space_inc};
   assign w_decide    = en && (r_state != IDLE) && (r_sym_cnt == SYM_LAST);
   assign w_bit       = w_mark_sum > w_space_sum;
   assign w_pred      = r_lfsr[4] ^ r_lfsr[2];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_sync     <= '0;
         r_prev     <= 1'b0;
         r_edge     <= 1'b0;
         r_hp       <= '0;
         r_mark     <= '0;
         r_space    <= '0;
         r_sym_cnt  <= '0;
         r_rx_bit   <= 1'b0;
         r_rx_valid <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], fsk_in};
         r_prev <= r_sync[1];
         r_edge <= r_sync[1] ^ r_prev;
         if (!en) begin
            r_hp       <= '0;
            r_mark     <= '0;
            r_space    <= '0;
            r_sym_cnt  <= '0;
            r_rx_bit   <= 1'b0;
            r_rx_valid <= 1'b0;
         end else begin
            if (r_edge)
               r_hp <= '0;
            else if (r_hp != 7'h7F)
               r_hp <= r_hp + 7'd1;
            r_rx_valid <= w_decide;
            if (w_decide)
               r_rx_bit <= w_bit;
            if (r_state == IDLE) begin
               // The starting edge only aligns symbol timing; it casts no vote
               r_mark    <= '0;
               r_space   <= '0;
               r_sym_cnt <= '0;
            end else begin
               r_sym_cnt <= (r_sym_cnt == SYM_LAST) ? '0 : r_sym_cnt + 1'b1;
               r_mark    <= w_decide ? 8'd0 : w_mark_sum;
               r_space   <= w_decide ? 8'd0 : w_space_sum;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state     <= IDLE;
         r_seed_cnt  <= '0;
         r_match_run <= '0;
         r_miss_run  <= '0;
         r_lfsr      <= '0;
         r_lock      <= 1'b0;
         r_err       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_seed_cnt  <= w_seed_cnt_nxt;
         r_match_run <= w_match_run_nxt;
         r_miss_run  <= w_miss_run_nxt;
         r_lfsr      <= w_lfsr_nxt;
         r_lock      <= w_lock_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_seed_cnt_nxt  = r_seed_cnt;
      w_match_run_nxt = r_match_run;
      w_miss_run_nxt  = r_miss_run;
      w_lfsr_nxt      = r_lfsr;
      w_lock_nxt      = r_lock;
      w_err_nxt       = r_err;
      if (!en) begin
         w_state_nxt     = IDLE;
         w_seed_cnt_nxt  = '0;
         w_match_run_nxt = '0;
         w_miss_run_nxt  = '0;
         w_lfsr_nxt      = '0;
         w_lock_nxt      = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_edge)
                  w_state_nxt = SEED;
            end
            SEED: begin
               if (w_decide) begin
                  w_lfsr_nxt = {r_lfsr[3:0], w_bit};
                  if (r_seed_cnt == 3'd4) begin
                     // An all-zero seed would lock up the LFSR, so gather a fresh one
                     w_seed_cnt_nxt = '0;
                     if (w_lfsr_nxt != 5'd0) begin
                        w_state_nxt     = CHECK;
                        w_match_run_nxt = '0;
                        w_miss_run_nxt  = '0;
                     end
                  end else begin
                     w_seed_cnt_nxt = r_seed_cnt + 3'd1;
                  end
               end
            end
            CHECK: begin
               if (w_decide) begin
                  // Free-run on the prediction so a bad symbol never corrupts the local state
                  w_lfsr_nxt = {r_lfsr[3:0], w_pred};
                  if (w_bit == w_pred) begin
                     w_miss_run_nxt = '0;
                     if (r_match_run != 8'hFF)
                        w_match_run_nxt = r_match_run + 8'd1;
                     if (w_match_run_nxt >= 8'(LOCK_RUN))
                        w_lock_nxt = 1'b1;
                  end else begin
                     w_match_run_nxt = '0;
                     if (r_miss_run != 8'hFF)
                        w_miss_run_nxt = r_miss_run + 8'd1;
                     if (r_lock && (r_err != 8'hFF))
                        w_err_nxt = r_err + 8'd1;
                     if (w_miss_run_nxt >= 8'(LOSS_RUN)) begin
                        w_lock_nxt     = 1'b0;
                        w_state_nxt    = SEED;
                        w_seed_cnt_nxt = '0;
                        w_miss_run_nxt = '0;
                     end
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      if (err_clr)
         w_err_nxt = '0;
   end

   assign rx_bit     = r_rx_bit;
   assign rx_valid   = r_rx_valid;
   assign lock       = r_lock;
   assign lfsr_state = r_lfsr;
   assign err_count  = r_err;
endmodule

// File: tb/tb_mbs_fsk_rx.sv
// Directed bench for mbs_fsk_rx: a background transmitter plays queued symbols as FSK
// (mark half-period 4, space 8) and each test task checks decoded bits, lock and err_count.
module tb_mbs_fsk_rx;
   localparam int SYM = 128;

   logic       clk = 1'b0;
   logic       rst, en, fsk, err_clr;
   logic       rx_bit, rx_valid, lock;
   logic [4:0] lfsr_state;
   logic [7:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat0    = 0;
   int tx_start_cyc = 0;
   bit tx_busy = 1'b0;
   bit tx_q[$];
   bit seq [0:511];

   mbs_fsk_rx #(.SYM_CYCLES(SYM)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .en        (en),
      .fsk_in    (fsk),
      .err_clr   (err_clr),
      .rx_bit    (rx_bit),
      .rx_valid  (rx_valid),
      .lock      (lock),
      .lfsr_state(lfsr_state),
      .err_count (err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter: every symbol has an even number of toggles, so fsk rests at 0 when idle
   initial begin
      bit b;
      int hp;
      fsk = 1'b0;
      @(negedge clk);
      forever begin
         if (tx_q.size() > 0) begin
            if (!tx_busy) tx_start_cyc = cyc;
            tx_busy = 1'b1;
            b  = tx_q.pop_front();
            hp = b ? 4 : 8;
            for (int k = 0; k < SYM / hp; k++) begin
               fsk = ~fsk;
               repeat (hp) @(negedge clk);
            end
         end else begin
            tx_busy = 1'b0;
            @(negedge clk);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: run did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic get_strobe(output bit b, output bit to, output int at);
      to = 1'b1; b = 1'b0; at = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (rx_valid) begin
            b = rx_bit; at = cyc; to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_tx_idle(output bit to);
      to = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (tx_q.size() == 0 && !tx_busy) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_reset();
      bit to;
      wait_tx_idle(to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL tx_idle: transmitter still busy=%0d, required 0", tx_busy); end
      rst = 1'b1; en = 1'b1; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      bit seen = 1'b0;
      rst = 1'b1; en = 1'b1; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
      n_tests++; if (rx_bit !== 1'b0) begin n_fail++; $display("FAIL reset_rx_bit: got %b, required 0", rx_bit); end
      n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b, required 0", lock); end
      n_tests++; if (lfsr_state !== 5'd0) begin n_fail++; $display("FAIL reset_lfsr: got %h, required 0", lfsr_state); end
      n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d, required 0", err_count); end
      rst = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rx_valid) seen = 1'b1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_no_strobe: rx_valid seen=%b, required 0", seen); end
      n_tests++; if (lock !== 1'b0 || lfsr_state !== 5'd0) begin n_fail++; $display("FAIL idle_state: lock=%b lfsr=%h, required 0/0", lock, lfsr_state); end
   endtask

   task automatic test_lock();
      bit b, to;
      int at;
      logic [4:0] exp_s;
      exp_s = 5'd0;
      do_reset();
      for (int i = 0; i < 12; i++) tx_q.push_back(seq[i]);
      for (int i = 0; i < 12; i++) begin
         get_strobe(b, to, at);
         if (i == 0) lat0 = at - tx_start_cyc;
         exp_s = {exp_s[3:0], seq[i]};
         n_tests++; if (to || b !== seq[i]) begin n_fail++; $display("FAIL lock_bit[%0d]: got %b timeout=%b, required %b", i, b, to, seq[i]); end
         n_tests++; if (lock !== (i >= 9)) begin n_fail++; $display("FAIL lock_flag[%0d]: got %b, required %b", i, lock, (i >= 9)); end
         n_tests++; if (lfsr_state !== exp_s) begin n_fail++; $display("FAIL lock_lfsr[%0d]: got %h, required %h", i, lfsr_state, exp_s); end
      end
      n_tests++; if (lat0 < 129 || lat0 > 135) begin n_fail++; $display("FAIL first_latency: got %0d, required 129..135", lat0); end
      n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err: got %0d, required 0", err_count); end
   endtask

   task automatic test_errors();
      bit b, to, inv;
      int at;
      bit txb [0:25];
      do_reset();
      for (int i = 0; i < 26; i++) begin
         inv = (i == 10) || (i >= 13 && i <= 15);
         txb[i] = seq[i] ^ inv;
         tx_q.push_back(txb[i]);
      end
      for (int i = 0; i < 26; i++) begin
         get_strobe(b, to, at);
         n_tests++; if (to || b !== txb[i]) begin n_fail++; $display("FAIL err_bit[%0d]: got %b timeout=%b, required %b", i, b, to, txb[i]); end
         if (i == 10) begin
            n_tests++; if (err_count !== 8'd1 || lock !== 1'b1) begin n_fail++; $display("FAIL single_err: err=%0d lock=%b, required 1/1", err_count, lock); end
         end
         if (i == 14) begin
            n_tests++; if (err_count !== 8'd3 || lock !== 1'b1) begin n_fail++; $display("FAIL second_miss: err=%0d lock=%b, required 3/1", err_count, lock); end
         end
         if (i == 15) begin
            n_tests++; if (err_count !== 8'd4 || lock !== 1'b0) begin n_fail++; $display("FAIL loss: err=%0d lock=%b, required 4/0", err_count, lock); end
         end
         if (i == 24) begin
            n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL relock_early: lock=%b, required 0", lock); end
         end
         if (i == 25) begin
            n_tests++; if (lock !== 1'b1 || err_count !== 8'd4) begin n_fail++; $display("FAIL relock: lock=%b err=%0d, required 1/4", lock, err_count); end
         end
      end
   endtask

   task automatic test_zero_seed();
      bit b, to;
      int at;
      do_reset();
      for (int i = 0; i < 10; i++) tx_q.push_back(1'b0);
      for (int i = 0; i < 10; i++) begin
         get_strobe(b, to, at);
         n_tests++; if (to || b !== 1'b0) begin n_fail++; $display("FAIL zero_bit[%0d]: got %b timeout=%b, required 0", i, b, to); end
         if (i == 4) begin
            n_tests++; if (lfsr_state !== 5'd0 || lock !== 1'b0) begin n_fail++; $display("FAIL zero_seed: lfsr=%h lock=%b, required 0/0", lfsr_state, lock); end
         end
      end
      n_tests++; if (lock !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL zero_nolock: lock=%b err=%0d, required 0/0", lock, err_count); end
   endtask

   task automatic test_err_sat();
      bit b, to;
      int at;
      int exp_err;
      bit txb  [0:395];
      bit invf [0:395];
      exp_err = 0;
      do_reset();
      for (int i = 0; i < 396; i++) begin
         invf[i] = (i >= 10 && i < 394) ? ((i - 10) % 3 != 2) : (i == 394);
         txb[i]  = seq[i] ^ invf[i];
         tx_q.push_back(txb[i]);
      end
      for (int i = 0; i < 394; i++) begin
         get_strobe(b, to, at);
         n_tests++; if (to || b !== txb[i]) begin n_fail++; $display("FAIL sat_bit[%0d]: got %b timeout=%b, required %b", i, b, to, txb[i]); end
         if (invf[i]) begin
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            n_tests++; if (err_count !== 8'(exp_err) || lock !== 1'b1) begin n_fail++; $display("FAIL sat_err[%0d]: err=%0d lock=%b, required %0d/1", i, err_count, lock, exp_err); end
         end
      end
      // Symbol 394 is an error; pulse err_clr exactly in its decision cycle
      repeat (127) @(posedge clk);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_tests++; if (rx_valid !== 1'b1 || rx_bit !== txb[394]) begin n_fail++; $display("FAIL clr_strobe: valid=%b bit=%b, required 1/%b", rx_valid, rx_bit, txb[394]); end
      n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clr_priority: err=%0d, required 0", err_count); end
   endtask

   task automatic test_en_drop();
      bit b, to;
      int at;
      bit txb [0:11];
      do_reset();
      for (int i = 0; i < 12; i++) begin
         txb[i] = seq[i] ^ (i == 10);
         tx_q.push_back(txb[i]);
      end
      for (int i = 0; i < 11; i++) begin
         get_strobe(b, to, at);
         n_tests++; if (to || b !== txb[i]) begin n_fail++; $display("FAIL en_bit[%0d]: got %b timeout=%b, required %b", i, b, to, txb[i]); end
      end
      n_tests++; if (lock !== 1'b1 || err_count !== 8'd1) begin n_fail++; $display("FAIL en_pre: lock=%b err=%0d, required 1/1", lock, err_count); end
      repeat (60) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      n_tests++; if (rx_valid !== 1'b0 || rx_bit !== 1'b0 || lock !== 1'b0 || lfsr_state !== 5'd0) begin
         n_fail++; $display("FAIL en_drop: valid=%b bit=%b lock=%b lfsr=%h, required all 0", rx_valid, rx_bit, lock, lfsr_state);
      end
      n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL en_err_hold: err=%0d, required 1", err_count); end
      en = 1'b1;
      wait_tx_idle(to);
      n_tests++; if (to) begin n_fail++; $display("FAIL en_tx_idle: busy=%0d, required 0", tx_busy); end
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 5; i++) tx_q.push_back(seq[i]);
      for (int i = 0; i < 5; i++) begin
         get_strobe(b, to, at);
         if (i == 0) begin
            n_tests++; if (to || (at - tx_start_cyc) !== lat0) begin n_fail++; $display("FAIL restart_latency: got %0d timeout=%b, required %0d", at - tx_start_cyc, to, lat0); end
         end
         n_tests++; if (to || b !== seq[i]) begin n_fail++; $display("FAIL restart_bit[%0d]: got %b timeout=%b, required %b", i, b, to, seq[i]); end
      end
      n_tests++; if (lfsr_state !== 5'b00001 || err_count !== 8'd1) begin n_fail++; $display("FAIL restart_seed: lfsr=%h err=%0d, required 01/1", lfsr_state, err_count); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++)
         seq[i] = (i < 5) ? (i == 4) : (seq[i-5] ^ seq[i-3]);
      test_reset();
      test_lock();
      test_errors();
      test_zero_seed();
      test_err_sat();
      test_en_drop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
